// File: rtl/ring_monitor.sv
// ring_monitor: run-time health checker for a one-hot rotating ring counter.
// Confirms each sample is one-hot and one place on from the previous sample in the
// configured direction. It locks after LOCK_N correct rotations, counts full
// revolutions, and flags any illegal or out-of-order sample.
// Optional feature macro: RING_MON_AUTORELOCK_EN. When it is defined, FAULT leaves to
// ACQUIRE after one cycle. Otherwise FAULT is sticky until clr, en=0 or reset.
module ring_monitor #(
   parameter int W      = 4,
   parameter int DIR    = 0,
   parameter int LOCK_N = 2,
   parameter int ECW    = 4,
   parameter int RCW    = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en,
   input  logic                 clr,
   input  logic [W-1:0]         ring_in,
   output logic                 locked,
   output logic                 fault,
   output logic [$clog2(W)-1:0] phase,
   output logic                 rev_tick,
   output logic [RCW-1:0]       rev_cnt,
   output logic [ECW-1:0]       err_cnt
);

   typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED, FAULT} state_t;

   // The ring's reset value: the first position of every revolution.
   localparam logic [W-1:0] START = (DIR == 0) ? (W'(1) << (W - 1)) : W'(1);

   state_t         state;
   logic [W-1:0]   prev;
   logic           prev_vld;
   logic [3:0]     good_cnt;
   logic [W-1:0]   exp_ring;
   logic           onehot;

   function automatic logic is_onehot(input logic [W-1:0] v);
      int n;
      n = 0;
      for (int i = 0; i < W; i++) n += int'(v[i]);
      return (n == 1);
   endfunction

   function automatic logic [W-1:0] rotate(input logic [W-1:0] v);
      if (DIR == 0) return {v[0], v[W-1:1]};
      else          return {v[W-2:0], v[W-1]};
   endfunction

   function automatic logic [$clog2(W)-1:0] bit_index(input logic [W-1:0] v);
      logic [$clog2(W)-1:0] idx;
      idx = '0;
      for (int i = 0; i < W; i++) if (v[i]) idx = ($clog2(W))'(i);
      return idx;
   endfunction

   function automatic logic [ECW-1:0] sat_inc(input logic [ECW-1:0] v);
      return (&v) ? v : v + ECW'(1);
   endfunction

   // Combinational one-hot check and the expected next ring value.
   always_comb begin
      onehot   = is_onehot(ring_in);
      exp_ring = rotate(prev);
   end

   // Monitor FSM. All outputs are registered. Clear outranks enable.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         prev     <= '0;
         prev_vld <= 1'b0;
         phase    <= '0;
         good_cnt <= '0;
         rev_cnt  <= '0;
         err_cnt  <= '0;
         locked   <= 1'b0;
         fault    <= 1'b0;
         rev_tick <= 1'b0;
      end else begin
         rev_tick <= 1'b0;
         if (clr) begin
            fault    <= 1'b0;
            locked   <= 1'b0;
            rev_cnt  <= '0;
            err_cnt  <= '0;
            good_cnt <= '0;
            prev     <= '0;
            prev_vld <= 1'b0;
            state    <= en ? ACQUIRE : IDLE;
         end else if (!en) begin
            state    <= IDLE;
            locked   <= 1'b0;
            fault    <= 1'b0;
            good_cnt <= '0;
            prev     <= '0;
            prev_vld <= 1'b0;
         end else begin
            case (state)
               IDLE: state <= ACQUIRE;
               ACQUIRE: begin
                  if (onehot) begin
                     prev     <= ring_in;
                     prev_vld <= 1'b1;
                     phase    <= bit_index(ring_in);
                     if (prev_vld && ring_in == exp_ring) begin
                        good_cnt <= good_cnt + 4'd1;
                        if (good_cnt + 4'd1 == 4'(LOCK_N)) begin
                           state  <= LOCKED;
                           locked <= 1'b1;
                        end
                     end else begin
                        good_cnt <= '0;
                     end
                  end else begin
                     good_cnt <= '0;
                     prev_vld <= 1'b0;
                  end
               end
               LOCKED: begin
                  if (ring_in == exp_ring) begin
                     prev  <= ring_in;
                     phase <= bit_index(ring_in);
                     if (ring_in == START) begin
                        rev_tick <= 1'b1;
                        rev_cnt  <= rev_cnt + RCW'(1);
                     end
                  end else begin
                     state    <= FAULT;
                     err_cnt  <= sat_inc(err_cnt);
                     locked   <= 1'b0;
                     fault    <= 1'b1;
                     good_cnt <= '0;
                  end
               end
               FAULT: begin
`ifdef RING_MON_AUTORELOCK_EN
                  // Relock must be earned from a fresh capture.
                  state    <= ACQUIRE;
                  fault    <= 1'b0;
                  good_cnt <= '0;
                  prev_vld <= 1'b0;
`else
                  state <= FAULT;
`endif
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ring_monitor.sv
// tb_ring_monitor: scoreboard bench for ring_monitor with W=4, DIR=0, LOCK_N=2,
// ECW=4, RCW=8. Each step drives one sample and queues its hand-derived expected
// outputs. The queued values are popped and compared just after the clock edge.
module tb_ring_monitor;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b0;
   logic       clr = 1'b0;
   logic [3:0] ring_in = 4'b0000;
   logic       locked, fault, rev_tick;
   logic [1:0] phase;
   logic [7:0] rev_cnt;
   logic [3:0] err_cnt;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic       locked;
      logic       fault;
      logic [1:0] phase;
      logic       tick;
      logic [7:0] rev;
      logic [3:0] err;
   } exp_t;

   exp_t sb[$];

   ring_monitor #(.W(4), .DIR(0), .LOCK_N(2), .ECW(4), .RCW(8)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .ring_in(ring_in),
      .locked(locked), .fault(fault), .phase(phase), .rev_tick(rev_tick),
      .rev_cnt(rev_cnt), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h @%0t", tag, act, exp, $time);
      end
   endtask

   // Drive one sample (called at a falling edge), queue its expectation, compare after the edge.
   task automatic step(input logic e, input logic c, input logic [3:0] r,
                       input logic l, input logic f, input logic [1:0] p,
                       input logic t, input logic [7:0] rv, input logic [3:0] er);
      exp_t x;
      en = e; clr = c; ring_in = r;
      x.locked = l; x.fault = f; x.phase = p; x.tick = t; x.rev = rv; x.err = er;
      sb.push_back(x);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         chk("sb_empty", 32'd0, 32'd1);
      end else begin
         x = sb.pop_front();
         chk("locked", 32'(locked), 32'(x.locked));
         chk("fault", 32'(fault), 32'(x.fault));
         chk("phase", 32'(phase), 32'(x.phase));
         chk("rev_tick", 32'(rev_tick), 32'(x.tick));
         chk("rev_cnt", 32'(rev_cnt), 32'(x.rev));
         chk("err_cnt", 32'(err_cnt), 32'(x.err));
      end
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [3:0] e;
      logic [1:0] p;

      // Reset values
      #12;
      chk("rst_locked", 32'(locked), 32'd0);
      chk("rst_fault", 32'(fault), 32'd0);
      chk("rst_phase", 32'(phase), 32'd0);
      chk("rst_tick", 32'(rev_tick), 32'd0);
      chk("rst_rev", 32'(rev_cnt), 32'd0);
      chk("rst_err", 32'(err_cnt), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Acquire, lock, and one full revolution
      step(1, 0, 4'b1000, 0, 0, 0, 0, 0, 0); // IDLE -> ACQUIRE
      step(1, 0, 4'b1000, 0, 0, 3, 0, 0, 0); // capture
      step(1, 0, 4'b0100, 0, 0, 2, 0, 0, 0);
      step(1, 0, 4'b0010, 1, 0, 1, 0, 0, 0); // locked
      step(1, 0, 4'b0001, 1, 0, 0, 0, 0, 0);
      step(1, 0, 4'b1000, 1, 0, 3, 1, 1, 0); // revolution
      step(1, 0, 4'b0100, 1, 0, 2, 0, 1, 0);

      // Non-one-hot while locked, then sticky fault
      step(1, 0, 4'b0110, 0, 1, 2, 0, 1, 1);
      step(1, 0, 4'b0010, 0, 1, 2, 0, 1, 1);
      step(1, 0, 4'b0001, 0, 1, 2, 0, 1, 1);
      step(1, 0, 4'b1000, 0, 1, 2, 0, 1, 1);

      // en=0 clears fault, counters hold
      step(0, 0, 4'b1000, 0, 0, 2, 0, 1, 1);

      // Relock, then a skip violation
      step(1, 0, 4'b1000, 0, 0, 2, 0, 1, 1);
      step(1, 0, 4'b1000, 0, 0, 3, 0, 1, 1);
      step(1, 0, 4'b0100, 0, 0, 2, 0, 1, 1);
      step(1, 0, 4'b0010, 1, 0, 1, 0, 1, 1);
      step(1, 0, 4'b0001, 1, 0, 0, 0, 1, 1);
      step(1, 0, 4'b1000, 1, 0, 3, 1, 2, 1);
      step(1, 0, 4'b0010, 0, 1, 3, 0, 2, 2); // skip

      // clr, relock, then a hold violation
      step(1, 1, 4'b0100, 0, 0, 3, 0, 0, 0);
      step(1, 0, 4'b0100, 0, 0, 2, 0, 0, 0);
      step(1, 0, 4'b0010, 0, 0, 1, 0, 0, 0);
      step(1, 0, 4'b0001, 1, 0, 0, 0, 0, 0);
      step(1, 0, 4'b1000, 1, 0, 3, 1, 1, 0);
      step(1, 0, 4'b1000, 0, 1, 3, 0, 1, 1); // hold

      // Error counter saturation via repeated fault / disable cycles
      e = 4'd1;
      p = 2'd3;
      for (int i = 0; i < 16; i++) begin
         step(0, 0, 4'b1000, 0, 0, p, 0, 1, e);
         step(1, 0, 4'b1000, 0, 0, p, 0, 1, e);
         step(1, 0, 4'b1000, 0, 0, 3, 0, 1, e);
         step(1, 0, 4'b0100, 0, 0, 2, 0, 1, e);
         step(1, 0, 4'b0010, 1, 0, 1, 0, 1, e);
         if (e != 4'hF) e = e + 4'd1;
         step(1, 0, 4'b0110, 0, 1, 1, 0, 1, e);
         p = 2'd1;
      end
      chk("err_sat", 32'(err_cnt), 32'hF);

      // clr wipes the history, then relock after two rotations
      step(1, 1, 4'b1000, 0, 0, 1, 0, 0, 0);
      step(1, 0, 4'b1000, 0, 0, 3, 0, 0, 0);
      step(1, 0, 4'b0100, 0, 0, 2, 0, 0, 0);
      step(1, 0, 4'b0010, 1, 0, 1, 0, 0, 0);
      step(1, 0, 4'b0001, 1, 0, 0, 0, 0, 0);
      step(1, 0, 4'b1000, 1, 0, 3, 1, 1, 0);
      step(1, 0, 4'b0100, 1, 0, 2, 0, 1, 0);

      // Asynchronous reset mid-revolution
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_locked", 32'(locked), 32'd0);
      chk("arst_phase", 32'(phase), 32'd0);
      chk("arst_rev", 32'(rev_cnt), 32'd0);
      chk("arst_err", 32'(err_cnt), 32'd0);
      chk("arst_fault", 32'(fault), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      en = 1'b0;
      @(negedge clk);

      // Relock, then en=0 holds rev_cnt
      step(1, 0, 4'b1000, 0, 0, 0, 0, 0, 0);
      step(1, 0, 4'b1000, 0, 0, 3, 0, 0, 0);
      step(1, 0, 4'b0100, 0, 0, 2, 0, 0, 0);
      step(1, 0, 4'b0010, 1, 0, 1, 0, 0, 0);
      step(1, 0, 4'b0001, 1, 0, 0, 0, 0, 0);
      step(1, 0, 4'b1000, 1, 0, 3, 1, 1, 0);
      step(0, 0, 4'b0100, 0, 0, 3, 0, 1, 0);

      // Two-bit sample while locked: auto relock or sticky fault
      step(1, 0, 4'b1000, 0, 0, 3, 0, 1, 0);
      step(1, 0, 4'b1000, 0, 0, 3, 0, 1, 0);
      step(1, 0, 4'b0100, 0, 0, 2, 0, 1, 0);
      step(1, 0, 4'b0010, 1, 0, 1, 0, 1, 0);
      step(1, 0, 4'b0011, 0, 1, 1, 0, 1, 1);
`ifdef RING_MON_AUTORELOCK_EN
      step(1, 0, 4'b0001, 0, 0, 1, 0, 1, 1); // fault lasts one cycle
      step(1, 0, 4'b0001, 0, 0, 0, 0, 1, 1); // fresh capture
      step(1, 0, 4'b1000, 0, 0, 3, 0, 1, 1);
      step(1, 0, 4'b0100, 1, 0, 2, 0, 1, 1);
`else
      step(1, 0, 4'b0001, 0, 1, 1, 0, 1, 1);
      step(1, 0, 4'b1000, 0, 1, 1, 0, 1, 1);
      step(1, 0, 4'b0100, 0, 1, 1, 0, 1, 1);
      step(1, 0, 4'b0010, 0, 1, 1, 0, 1, 1);
`endif

      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
